wave_synth: RTL and testbench

- Parametrised DDS-style waveform generator. It succeeds the fixed idle/square/triangle/saw selector.
- A phase accumulator drives four modes: IDLE, SQUARE, TRIANGLE and SAW.
- Adds programmable frequency, square duty cycle and amplitude scaling.
- Mode and frequency changes are glitch-free: they are deferred to phase wrap.
- Sits between the debounce/edge-detect front end and the DAC output pins.

---
 rtl/wave_synth_pkg.sv | 40 ++++
 rtl/wave_shaper.sv | 90 +++++++++
 rtl/wave_synth.sv | 158 +++++++++++++++
 tb/tb_wave_synth.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wave_synth_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : wave_synth_pkg
//  Description : Shared types and constants for the wave_synth DDS waveform
//                generator: mode encoding, mode-indicator colours and the
//                mode successor function.
//  Revision    : 1.0 - initial release
// ============================================================================
package wave_synth_pkg;

  // Active waveform mode. The encoding is visible on the mode output pins.
  typedef enum logic [1:0] {
    MODE_IDLE     = 2'd0,
    MODE_SQUARE   = 2'd1,
    MODE_TRIANGLE = 2'd2,
    MODE_SAW      = 2'd3
  } mode_t;

  // Mode indicator colours {r,g,b}
  localparam logic [2:0] RGB_IDLE     = 3'b000;
  localparam logic [2:0] RGB_SQUARE   = 3'b110;
  localparam logic [2:0] RGB_TRIANGLE = 3'b101;
  localparam logic [2:0] RGB_SAW      = 3'b011;
  localparam logic [2:0] RGB_ERROR    = 3'b100;

  // Mode cycle: IDLE -> SQUARE -> TRIANGLE -> SAW -> IDLE
  function automatic mode_t mode_succ(input mode_t m);
    mode_t r;
    case (m)
      MODE_IDLE:     r = MODE_SQUARE;
      MODE_SQUARE:   r = MODE_TRIANGLE;
      MODE_TRIANGLE: r = MODE_SAW;
      MODE_SAW:      r = MODE_IDLE;
      default:       r = MODE_IDLE;
    endcase
    return r;
  endfunction

endpackage : wave_synth_pkg
`default_nettype wire

// File: rtl/wave_shaper.sv
`default_nettype none
// ============================================================================
//  Module      : wave_shaper
//  Description : Stage 1 of the wave_synth pipeline. Maps the phase
//                accumulator value to an unscaled sample for the active mode
//                and registers it together with the mode indicator colour.
//  Ports       : clk      - system clock
//                rst      - asynchronous active-low reset
//                phase_i  - phase accumulator value
//                mode_i   - active mode
//                duty_i   - square-wave high fraction, duty/2^DUTY_W
//                raw_o    - registered unscaled sample
//                rgb_o    - registered mode indicator
//  Revision    : 1.0 - initial release
// ============================================================================
module wave_shaper
  import wave_synth_pkg::*;
#(
  parameter int OUT_W   = 12,
  parameter int PHASE_W = 24,
  parameter int DUTY_W  = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [PHASE_W-1:0] phase_i,
  input  mode_t              mode_i,
  input  logic [DUTY_W-1:0]  duty_i,
  output logic [OUT_W-1:0]   raw_o,
  output logic [2:0]         rgb_o
);

  logic [OUT_W-1:0]  p;
  logic [DUTY_W-1:0] d;
  logic [OUT_W-1:0]  ramp;
  logic [OUT_W-1:0]  raw_d, raw_q;
  logic [2:0]        rgb_d, rgb_q;

  // Only the top bits of the phase shape the output; the fractional LSBs
  // exist solely to give fine frequency resolution.
  logic              unused_phase_bits;
  assign unused_phase_bits = ^phase_i;

  assign p    = phase_i[PHASE_W-1 -: OUT_W];
  assign d    = phase_i[PHASE_W-1 -: DUTY_W];
  // Rising half of the triangle: p doubled; the falling half is its inverse,
  // which makes the two halves mirror images about the phase midpoint.
  assign ramp = {p[OUT_W-2:0], 1'b0};

  always_comb begin
    raw_d = '0;
    rgb_d = RGB_ERROR;
    case (mode_i)
      MODE_IDLE: begin
        raw_d = '0;
        rgb_d = RGB_IDLE;
      end
      MODE_SQUARE: begin
        raw_d = (d < duty_i) ? '1 : '0;
        rgb_d = RGB_SQUARE;
      end
      MODE_TRIANGLE: begin
        raw_d = p[OUT_W-1] ? ~ramp : ramp;
        rgb_d = RGB_TRIANGLE;
      end
      MODE_SAW: begin
        raw_d = p;
        rgb_d = RGB_SAW;
      end
      default: begin
        raw_d = '0;
        rgb_d = RGB_ERROR;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      raw_q <= '0;
      rgb_q <= RGB_IDLE;
    end else begin
      raw_q <= raw_d;
      rgb_q <= rgb_d;
    end
  end

  assign raw_o = raw_q;
  assign rgb_o = rgb_q;

endmodule : wave_shaper
`default_nettype wire

// File: rtl/wave_synth.sv
`default_nettype none
// ============================================================================
//  Module      : wave_synth
//  Description : DDS-style waveform generator. A phase accumulator feeds a
//                two-stage pipeline (shape, then amplitude scale). Mode and
//                frequency changes are deferred to phase wrap so the output
//                never glitches mid-period.
//  Ports       : clk         - system clock
//                rst         - asynchronous active-low reset
//                ena         - phase advance enable
//                next_mode   - single-cycle request for the next mode
//                tuning_word - phase increment per enabled cycle
//                duty        - square-wave high fraction
//                amp         - amplitude, signal = raw*(amp+1) >> DUTY_W
//                signal      - scaled sample (2-cycle latency)
//                rgb         - mode indicator (1-cycle latency)
//                mode        - active mode
//                wrap        - one-cycle pulse on accumulator carry-out
//  Revision    : 1.0 - initial release
// ============================================================================
module wave_synth
  import wave_synth_pkg::*;
#(
  parameter int OUT_W   = 12,
  parameter int PHASE_W = 24,
  parameter int DUTY_W  = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ena,
  input  logic               next_mode,
  input  logic [PHASE_W-1:0] tuning_word,
  input  logic [DUTY_W-1:0]  duty,
  input  logic [DUTY_W-1:0]  amp,
  output logic [OUT_W-1:0]   signal,
  output logic [2:0]         rgb,
  output logic [1:0]         mode,
  output logic               wrap
);

  localparam int PROD_W = OUT_W + DUTY_W + 1;

  logic [PHASE_W-1:0] phase_q, phase_d;
  logic [PHASE_W-1:0] tw_q, tw_d;
  logic               wrap_q, wrap_d;
  mode_t              mode_q, mode_d;
  mode_t              pend_q, pend_d;
  logic               pflag_q, pflag_d;
  logic [OUT_W-1:0]   signal_q, signal_d;

  logic [PHASE_W:0]   sum;
  logic               update_ok;
  logic [OUT_W-1:0]   raw;
  logic [DUTY_W:0]    amp_p1;
  logic [PROD_W-1:0]  prod;

  assign sum = {1'b0, phase_q} + {1'b0, tw_q};

  // Safe moments to swap frequency or mode: at a period boundary, while the
  // phase is frozen, while the accumulator is not moving, or while idle.
  assign update_ok = wrap_q | ~ena | (tw_q == '0) | (mode_q == MODE_IDLE);

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      phase_q  <= '0;
      tw_q     <= '0;
      wrap_q   <= 1'b0;
      mode_q   <= MODE_IDLE;
      pend_q   <= MODE_IDLE;
      pflag_q  <= 1'b0;
      signal_q <= '0;
    end else begin
      phase_q  <= phase_d;
      tw_q     <= tw_d;
      wrap_q   <= wrap_d;
      mode_q   <= mode_d;
      pend_q   <= pend_d;
      pflag_q  <= pflag_d;
      signal_q <= signal_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic: accumulator, frequency latch, mode FSM
  // --------------------------------------------------------------------------
  always_comb begin
    phase_d = phase_q;
    wrap_d  = 1'b0;
    if (ena) begin
      phase_d = sum[PHASE_W-1:0];
      wrap_d  = sum[PHASE_W];
    end

    tw_d = update_ok ? tuning_word : tw_q;

    mode_d  = mode_q;
    pend_d  = pend_q;
    pflag_d = pflag_q;
    if (update_ok) begin
      if (pflag_q) begin
        mode_d = pend_q;
      end
      pflag_d = 1'b0;
    end
    // A request landing on the commit cycle chains from the value being
    // committed and keeps the flag set for the following commit.
    if (next_mode) begin
      pend_d  = mode_succ(pend_q);
      pflag_d = 1'b1;
    end

    case (mode_q)
      MODE_IDLE, MODE_SQUARE, MODE_TRIANGLE, MODE_SAW: ;
      default: mode_d = MODE_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Stage 1: shaping
  // --------------------------------------------------------------------------
  wave_shaper #(
    .OUT_W   (OUT_W),
    .PHASE_W (PHASE_W),
    .DUTY_W  (DUTY_W)
  ) u_shaper (
    .clk     (clk),
    .rst     (rst),
    .phase_i (phase_q),
    .mode_i  (mode_q),
    .duty_i  (duty),
    .raw_o   (raw),
    .rgb_o   (rgb)
  );

  // --------------------------------------------------------------------------
  // Stage 2: scaling. amp+1 makes amp=all-ones an exact unity gain.
  // --------------------------------------------------------------------------
  assign amp_p1 = {1'b0, amp} + {{DUTY_W{1'b0}}, 1'b1};
  assign prod   = PROD_W'(raw) * PROD_W'(amp_p1);

  always_comb begin
    signal_d = OUT_W'(prod >> DUTY_W);
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  always_comb begin
    signal = signal_q;
    mode   = mode_q;
    wrap   = wrap_q;
  end

endmodule : wave_synth
`default_nettype wire

// File: tb/tb_wave_synth.sv
`default_nettype none
// ============================================================================
//  Module      : tb_wave_synth
//  Description : Self-checking bench for wave_synth. A cycle-level reference
//                model built from the mode rules and plain arithmetic runs
//                alongside the DUT under directed and random stimulus.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_wave_synth;

  localparam int OUT_W   = 12;
  localparam int PHASE_W = 16;
  localparam int DUTY_W  = 8;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               ena = 1'b0;
  logic               next_mode = 1'b0;
  logic [PHASE_W-1:0] tuning_word = '0;
  logic [DUTY_W-1:0]  duty = '0;
  logic [DUTY_W-1:0]  amp = 8'hFF;
  logic [OUT_W-1:0]   signal;
  logic [2:0]         rgb;
  logic [1:0]         mode;
  logic               wrap;

  wave_synth #(
    .OUT_W   (OUT_W),
    .PHASE_W (PHASE_W),
    .DUTY_W  (DUTY_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .ena         (ena),
    .next_mode   (next_mode),
    .tuning_word (tuning_word),
    .duty        (duty),
    .amp         (amp),
    .signal      (signal),
    .rgb         (rgb),
    .mode        (mode),
    .wrap        (wrap)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state (plain integers)
  int m_phase, m_tw, m_mode, m_pend, m_flag, m_wrap, m_raw, m_rgb, m_sig;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int shape(input int md, input int ph, input int dt);
    int p;
    p = ph / 16;                      // top 12 of 16 phase bits
    case (md)
      1:       return ((ph / 256) < dt) ? 4095 : 0;
      2:       return (p < 2048) ? 2 * p : 4095 - 2 * (p - 2048);
      3:       return p;
      default: return 0;
    endcase
  endfunction

  function automatic int rgb_of(input int md);
    case (md)
      1:       return 6;
      2:       return 5;
      3:       return 3;
      default: return 0;
    endcase
  endfunction

  task automatic model_reset();
    m_phase = 0; m_tw = 0; m_mode = 0; m_pend = 0; m_flag = 0;
    m_wrap = 0; m_raw = 0; m_rgb = 0; m_sig = 0;
  endtask

  task automatic model_step();
    int  sum, n_phase, n_wrap, n_tw, n_mode, n_pend, n_flag;
    bit  ok;
    ok      = (m_wrap == 1) || !ena || (m_tw == 0) || (m_mode == 0);
    sum     = m_phase + m_tw;
    n_phase = ena ? sum % 65536 : m_phase;
    n_wrap  = (ena && sum >= 65536) ? 1 : 0;
    n_tw    = ok ? int'(tuning_word) : m_tw;
    n_mode  = (ok && m_flag == 1) ? m_pend : m_mode;
    n_pend  = next_mode ? (m_pend + 1) % 4 : m_pend;
    n_flag  = next_mode ? 1 : (ok ? 0 : m_flag);
    m_sig   = (m_raw * (int'(amp) + 1)) / 256;
    m_raw   = shape(m_mode, m_phase, int'(duty));
    m_rgb   = rgb_of(m_mode);
    m_phase = n_phase; m_wrap = n_wrap; m_tw = n_tw;
    m_mode  = n_mode;  m_pend = n_pend; m_flag = n_flag;
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) model_step();
    else     model_reset();
    #1;
    check_eq("signal", 32'(signal), 32'(m_sig));
    check_eq("rgb",    32'(rgb),    32'(m_rgb));
    check_eq("mode",   32'(mode),   32'(m_mode));
    check_eq("wrap",   32'(wrap),   32'(m_wrap));
  endtask

  task automatic pulse();
    next_mode = 1'b1;
    tick();
    next_mode = 1'b0;
  endtask

  task automatic do_reset();
    #3;
    rst = 1'b0;
    #1;
    model_reset();
    check_eq("rst_signal", 32'(signal), 32'd0);
    check_eq("rst_rgb",    32'(rgb),    32'd0);
    check_eq("rst_mode",   32'(mode),   32'd0);
    check_eq("rst_wrap",   32'(wrap),   32'd0);
    tick();
    tick();
    rst = 1'b1;
    next_mode = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    check_eq("idle_hold_mode", 32'(mode), 32'd0);
  endtask

  task automatic goto_mode(input int target);
    for (int k = 0; k < 6; k++) begin
      if (m_mode == target && m_flag == 0) break;
      pulse();
      for (int w = 0; w < 64 && m_flag == 1; w++) tick();
    end
    check_eq("goto_mode", 32'(mode), 32'(target));
  endtask

  task automatic wait_wrap();
    for (int w = 0; w < 40; w++) begin
      tick();
      if (wrap) break;
    end
  endtask

  initial begin
    int cnt, mx;
    bit seen_tri;

    // ---------------- Reset / idle ----------------
    tick();
    tick();
    rst = 1'b1;
    ena = 1'b1;
    tuning_word = 16'h1000;
    amp = 8'hFF;
    for (int i = 0; i < 10; i++) tick();
    do_reset();

    // ---------------- Saw ----------------
    pulse();
    tick();
    check_eq("idle_to_square", 32'(mode), 32'd1);
    pulse();
    tick();
    pulse();
    for (int w = 0; w < 40 && m_flag == 1; w++) tick();
    check_eq("saw_commit", 32'(mode), 32'd3);
    cnt = 0;
    for (int i = 0; i < 32; i++) begin
      tick();
      if (wrap) cnt++;
    end
    check_eq("saw_wraps", 32'(cnt), 32'd2);

    // ---------------- Square duty ----------------
    goto_mode(1);
    duty = 8'h40;
    for (int i = 0; i < 4; i++) tick();
    cnt = 0;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (signal == 12'hFFF) cnt++;
    end
    check_eq("sq_duty40_high", 32'(cnt), 32'd4);
    duty = 8'h00;
    for (int i = 0; i < 3; i++) tick();
    cnt = 0;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (signal != 0) cnt++;
    end
    check_eq("sq_duty0_high", 32'(cnt), 32'd0);

    // ---------------- Triangle and scale ----------------
    goto_mode(2);
    amp = 8'h7F;
    for (int i = 0; i < 3; i++) tick();
    mx = 0;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (int'(signal) > mx) mx = int'(signal);
    end
    check_eq("tri_peak", 32'(mx), 32'h7FF);
    amp = 8'h00;
    for (int i = 0; i < 3; i++) tick();
    mx = 0;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (int'(signal) > mx) mx = int'(signal);
    end
    check_eq("tri_amp0_max", 32'(mx), 32'h00F);
    amp = 8'hFF;

    // ---------------- Deferred change ----------------
    goto_mode(3);
    for (int w = 0; w < 40 && m_phase != 16'h2000; w++) tick();
    tuning_word = 16'h0800;
    pulse();
    for (int w = 0; w < 20; w++) begin
      tick();
      if (wrap) break;
      check_eq("defer_hold", 32'(mode), 32'd3);
    end
    check_eq("defer_wrap_seen", 32'(wrap), 32'd1);
    tick();
    check_eq("defer_idle", 32'(mode), 32'd0);
    for (int i = 0; i < 40; i++) tick();

    // ---------------- Simultaneous pulses ----------------
    tuning_word = 16'h1000;
    goto_mode(1);
    wait_wrap();
    tick();
    pulse();
    tick();
    pulse();
    seen_tri = 1'b0;
    for (int w = 0; w < 40 && m_flag == 1; w++) begin
      tick();
      if (mode == 2'd2) seen_tri = 1'b1;
    end
    check_eq("simul_skip_tri", 32'(seen_tri), 32'd0);
    check_eq("simul_saw", 32'(mode), 32'd3);

    // ---------------- Stalled ----------------
    ena = 1'b0;
    tick();
    pulse();
    tick();
    check_eq("stall_commit", 32'(mode), 32'd0);
    pulse();
    for (int i = 0; i < 6; i++) tick();
    check_eq("stall_square", 32'(mode), 32'd1);
    ena = 1'b1;

    // ---------------- Random ----------------
    for (int i = 0; i < 1500; i++) begin
      if (i == 700) do_reset();
      ena       = ($urandom_range(0, 9) != 0);
      next_mode = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 49) == 0) tuning_word = PHASE_W'($urandom_range(0, 16'h2000));
      if ($urandom_range(0, 29) == 0) duty = DUTY_W'($urandom);
      if ($urandom_range(0, 29) == 0) amp  = DUTY_W'($urandom);
      tick();
    end
    next_mode = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_wave_synth
`default_nettype wire
